// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter (1 start, 8 data LSB first, 1 stop) fed by CPU stores.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (11-bit frame).
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic            sysclk,
  input  logic            cpu_reset,
  input  logic            wr_i,
  input  logic [7:0]      data_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [ADDR_W:0] count_o,
  output logic            busy_o,
  output logic [7:0]      drop_cnt_o,
  output logic            uart_tx_o
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [ADDR_W:0]  DEPTH     = (ADDR_W + 1)'(FIFO_DEPTH);

  // state  | meaning
  // IDLE   | line high, waiting for a queued byte
  // START  | start bit (low)
  // DATA   | eight data bits, LSB first
  // PARITY | even parity bit (parity build only)
  // STOP   | stop bit (high); may chain straight into the next START
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state, state_n;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count_n;
  logic [CNT_W-1:0]    baud_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;
  logic                push, pop, bit_end, tx_n;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // A write while full is dropped even if the FSM pops on the same edge.
  always_comb begin
    push    = wr_i && !full_o;
    count_n = count_o + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty_o) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shift[bit_idx];
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_n = ^shift;
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!empty_o) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (push && !cpu_reset) mem[wr_ptr] <= data_i;
  end

  // Line and busy are registered from the current state, so both trail the FSM by one cycle.
  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      empty_o    <= 1'b1;
      full_o     <= 1'b0;
      busy_o     <= 1'b0;
      drop_cnt_o <= 8'd0;
      uart_tx_o  <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'd0;
    end else begin
      state     <= state_n;
      uart_tx_o <= tx_n;
      busy_o    <= (state != IDLE);
      count_o   <= count_n;
      empty_o   <= (count_n == '0);
      full_o    <= (count_n == DEPTH);
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        shift  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (wr_i && full_o && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + CNT_W'(1);
      if (state != DATA)   bit_idx <= 3'd0;
      else if (bit_end)    bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a line-decoding scoreboard monitor for uart_tx_fifo.
// Expected bytes are queued at write time; the monitor decodes each frame and pops/compares.
module tb_uart_tx_fifo;

  localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = BAUD * NB;

  logic       sysclk = 1'b0;
  logic       cpu_reset = 1'b1;
  logic       wr_i = 1'b0;
  logic [7:0] data_i = 8'd0;
  logic       full_o, empty_o, busy_o, uart_tx_o;
  logic [4:0] count_o;
  logic [7:0] drop_cnt_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(16), .ADDR_W(4)) dut (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .wr_i(wr_i), .data_i(data_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .busy_o(busy_o),
    .drop_cnt_o(drop_cnt_o), .uart_tx_o(uart_tx_o)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, expv);
    end
  endtask

  // Monitor: first low sample is offset 0 of the start bit; bit k is sampled mid-bit at offset 4k+2.
  logic [NB-1:0] mon_bits;
  logic          mon_abort;
  logic [7:0]    mon_exp;
  int            mon_st;
  initial begin : monitor
    forever begin
      @(negedge sysclk);
      if (!cpu_reset && uart_tx_o === 1'b0) begin
        mon_abort = 1'b0;
        mon_st = cyc;
        for (int k = 0; k < NB; k++) begin
          repeat ((k == 0) ? 2 : BAUD) begin
            @(negedge sysclk);
            if (cpu_reset) mon_abort = 1'b1;
          end
          mon_bits[k] = uart_tx_o;
        end
        if (!mon_abort) begin
          starts.push_back(mon_st);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got byte %02h with no byte queued", mon_bits[8:1]);
          end else begin
            mon_exp = exp_q.pop_front();
            check("frame_byte", 32'(mon_bits[8:1]), 32'(mon_exp));
            check("frame_start_stop", {30'd0, mon_bits[NB-1], mon_bits[0]}, 32'd2);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", 32'(mon_bits[9]), 32'(^mon_exp));
`endif
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int e_cyc, errs, nfull, seq, ns, lows, gap;
`ifdef UART_TX_PARITY_EN
    logic [NB-1:0] pat41 = 11'b10010000010;
`else
    logic [NB-1:0] pat41 = 10'b1010000010;
`endif

    // Reset held for three edges
    repeat (3) @(negedge sysclk);
    cpu_reset = 1'b0;
    check("rst_tx", 32'(uart_tx_o), 32'd1);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_drop", 32'(drop_cnt_o), 32'd0);

    // Single byte 0x41: line falls at E+2, frame of NB levels x 4 cycles
    @(negedge sysclk);
    wr_i = 1'b1; data_i = 8'h41; exp_q.push_back(8'h41);
    @(negedge sysclk);
    wr_i = 1'b0;
    check("single_count_e0", 32'(count_o), 32'd1);
    check("single_empty_e0", 32'(empty_o), 32'd0);
    @(negedge sysclk);
    check("single_tx_e1", 32'(uart_tx_o), 32'd1);
    check("single_busy_e1", 32'(busy_o), 32'd0);
    @(negedge sysclk);
    check("single_tx_e2", 32'(uart_tx_o), 32'd0);
    check("single_busy_e2", 32'(busy_o), 32'd1);
    errs = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge sysclk);
      if (uart_tx_o !== pat41[c / BAUD]) errs++;
    end
    check("single_line_pattern", 32'(errs), 32'd0);
    check("single_busy_last", 32'(busy_o), 32'd1);
    @(negedge sysclk);
    check("single_busy_end", 32'(busy_o), 32'd0);
    check("single_tx_end", 32'(uart_tx_o), 32'd1);
    repeat (5) @(negedge sysclk);

    // Burst of 18 writes: 0x00..0x10 accepted, 0x11 dropped
    e_cyc = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 16) check("burst_full_e15", 32'(full_o), 32'd0);
      if (i == 17) begin
        check("burst_full_e16", 32'(full_o), 32'd1);
        check("burst_count_e16", 32'(count_o), 32'd16);
      end
      wr_i = 1'b1; data_i = 8'(i);
      if (i < 17) exp_q.push_back(8'(i));
      @(negedge sysclk);
      if (i == 0) e_cyc = cyc;
    end
    wr_i = 1'b0;
    check("burst_drop", 32'(drop_cnt_o), 32'd1);
    check("burst_full_e17", 32'(full_o), 32'd1);
    repeat (17 * FRAME + 2 - 17 - 1) @(negedge sysclk);
    check("burst_busy_before_end", 32'(busy_o), 32'd1);
    @(negedge sysclk);
    check("burst_busy_end", 32'(busy_o), 32'd0);
    check("burst_empty_end", 32'(empty_o), 32'd1);
    check("burst_frames", 32'(starts.size()), 32'd18);
    gap = (starts.size() >= 18) ? starts[17] - starts[1] : -1;
    check("burst_gapless", 32'(gap), 32'(16 * FRAME));
    check("burst_first_start", 32'((starts.size() >= 2) ? starts[1] - e_cyc : -1), 32'd2);
    repeat (5) @(negedge sysclk);

    // Drop-counter saturation: 300 writes while full, refilling whenever a slot opens
    nfull = 0; seq = 0;
    for (int i = 0; nfull < 300 && i < 3000; i++) begin
      wr_i = 1'b1;
      if (full_o) begin
        data_i = 8'hEE;
        nfull++;
      end else begin
        data_i = 8'(8'h80 + seq);
        exp_q.push_back(8'(8'h80 + seq));
        seq++;
      end
      @(negedge sysclk);
    end
    wr_i = 1'b0;
    check("sat_full_writes", 32'(nfull), 32'd300);
    check("sat_drop", 32'(drop_cnt_o), 32'd255);
    for (int i = 0; i < 30 * FRAME && !(exp_q.size() == 0 && !busy_o); i++) @(negedge sysclk);
    check("sat_drained", 32'(exp_q.size()), 32'd0);
    check("sat_idle", 32'(busy_o), 32'd0);
    check("sat_drop_hold", 32'(drop_cnt_o), 32'd255);
    repeat (5) @(negedge sysclk);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: parity bit 1; busy low 46 cycles after the write edge
    wr_i = 1'b1; data_i = 8'h07; exp_q.push_back(8'h07);
    @(negedge sysclk);
    wr_i = 1'b0;
    repeat (38) @(negedge sysclk);
    check("par_bit", 32'(uart_tx_o), 32'd1);
    repeat (7) @(negedge sysclk);
    check("par_busy_e45", 32'(busy_o), 32'd1);
    @(negedge sysclk);
    check("par_busy_e46", 32'(busy_o), 32'd0);
    repeat (5) @(negedge sysclk);
`endif

    // Reset mid-frame: 0x55 in data bit 3 with three bytes still queued
    for (int i = 0; i < 4; i++) begin
      wr_i = 1'b1;
      data_i = (i == 0) ? 8'h55 : 8'(8'hA0 + i);
      exp_q.push_back(data_i);
      @(negedge sysclk);
    end
    wr_i = 1'b0;
    check("mid_count_queued", 32'(count_o), 32'd3);
    repeat (16) @(negedge sysclk);
    check("mid_busy", 32'(busy_o), 32'd1);
    cpu_reset = 1'b1;
    exp_q.delete();
    ns = starts.size();
    @(negedge sysclk);
    cpu_reset = 1'b0;
    check("mid_tx", 32'(uart_tx_o), 32'd1);
    check("mid_count", 32'(count_o), 32'd0);
    check("mid_empty", 32'(empty_o), 32'd1);
    check("mid_busy_cleared", 32'(busy_o), 32'd0);
    check("mid_drop_cleared", 32'(drop_cnt_o), 32'd0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sysclk);
      if (uart_tx_o !== 1'b1) lows++;
    end
    check("mid_line_quiet", 32'(lows), 32'd0);
    check("mid_no_frames", 32'(starts.size()), 32'(ns));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter downstream of the CPU's memory-mapped UART store path.
- Accepts single-cycle byte writes, qualified by the CPU's store-to-UART-address decode, into a FIFO.
- Serializes bytes on a 1-start, 8-data (LSB first), 1-stop line.
- Decouples program execution from baud-rate timing: bursts of stores do not stall, and overflow is counted rather than silently lost.

Parameters:
- BAUD_DIV, 868, clock cycles per bit (100 MHz / 115200); minimum 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- cpu_reset  in  1  synchronous, active-high reset.
- wr_i  in  1  write strobe, one byte per cycle high.
- data_i  in  8  byte to transmit, sampled with wr_i.
- full_o  out  1  FIFO holds FIFO_DEPTH entries.
- empty_o  out  1  FIFO holds 0 entries.
- count_o  out  ADDR_W+1  current FIFO occupancy.
- busy_o  out  1  serializer not in IDLE.
- drop_cnt_o  out  8  bytes dropped on overflow; saturating.
- uart_tx_o  out  1  serial line; idles high.

Behaviour:
- Reset, synchronous on cpu_reset at an edge:
  - Pointers and count_o cleared to 0.
  - empty_o=1, full_o=0, busy_o=0, drop_cnt_o=0, uart_tx_o=1, state=IDLE.
  - Baud counter and bit index cleared to 0.
  - Reset has priority over every other event.
- Status outputs:
  - All outputs are registered.
  - full_o, empty_o and count_o reflect occupancy after the most recent edge.
- Push:
  - At an edge with wr_i=1 and full_o=0, data_i is written at wr_ptr; wr_ptr increments with wrap at FIFO_DEPTH.
  - At an edge with wr_i=1 and full_o=1, the byte is dropped and drop_cnt_o increments, saturating at 255.
  - A pop in the same cycle does not rescue a write while full_o=1.
- Pop:
  - Performed only by the FSM; rd_ptr increments with wrap.
  - A simultaneous push and pop leaves count_o unchanged.
- FSM states: IDLE, START, DATA, STOP.
- Baud counter: counts 0..BAUD_DIV-1 within each bit. The bit ends when the counter reaches BAUD_DIV-1.
- IDLE:
  - uart_tx_o=1.
  - If empty_o=0: pop head into shift register and go to START.
- START:
  - uart_tx_o=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
- DATA:
  - uart_tx_o=shift[bit index] for BAUD_DIV cycles per bit.
  - After bit 7, go to STOP.
- STOP:
  - uart_tx_o=1 for BAUD_DIV cycles.
  - On the last STOP cycle, if empty_o=0: pop and go directly to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- Latency:
  - wr_i sampled at edge E into an empty FIFO with the FSM in IDLE: uart_tx_o falls at edge E+2.
  - Frame length is exactly 10*BAUD_DIV cycles.
- Reset mid-frame: the frame is truncated, uart_tx_o=1 from the next edge, and FIFO contents are discarded.
- busy_o=1 in START, DATA and STOP.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - FSM gains a PARITY state between DATA and STOP.
  - PARITY drives even parity (XOR of the 8 data bits) for BAUD_DIV cycles.
  - Frame length is 11*BAUD_DIV.
- Undefined: no PARITY state, 8N1 framing, frame length 10*BAUD_DIV.

Test Plan:
- Reset: cpu_reset high 3 cycles -> uart_tx_o=1, empty_o=1, full_o=0, count_o=0, busy_o=0, drop_cnt_o=0.
- Single byte, BAUD_DIV=4: wr_i with 0x41 at edge E -> uart_tx_o falls at E+2; line sequence 0,1,0,0,0,0,0,1,0,1, each level 4 cycles; busy_o low at E+42.
- Burst overflow, BAUD_DIV=4: 18 consecutive writes 0x00..0x11 from edge E -> full_o=1 after E+16; 0x11 dropped; drop_cnt_o=1; line emits 0x00..0x10 in order as 17 gapless frames (680 cycles).
- Saturation: 300 writes while full_o=1 -> drop_cnt_o=255 and holds; FIFO contents unchanged.
- Reset mid-frame: 0x55 in DATA bit 3 with 3 bytes queued; assert cpu_reset -> uart_tx_o=1 next edge, count_o=0; no frames after release.
- Parity (UART_TX_PARITY_EN defined), BAUD_DIV=4: send 0x07 -> parity bit 1; frame 44 cycles; busy_o low 46 cycles after write edge.
